ps2_ascii_decoder: RTL and testbench

- Front-end keyboard stage of the ATM.
- Receives raw PS/2 clock/data from the keyboard, deserialises and checks 11-bit frames, and tracks make/break/extended prefixes.
- Translates set-2 scancodes to ASCII and presents ascii_code with a one-cycle ascii_valid strobe to the downstream account/PIN entry logic.
- Key presses only; releases update modifier state but never emit a code.

---
 rtl/ps2_ascii_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 keyboard front end: synchronise, glitch-filter, deframe, decode make codes to ASCII.
// Optional macro PS2_SHIFT_EN enables shift tracking (uppercase letters while 12/59 held).
module ps2_ascii_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_code,
  output logic       ascii_valid,
  output logic       frame_err
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic           r_filt;
  logic [FCW-1:0] r_fcnt;
  logic           w_fall;
  logic [3:0]     r_bitcnt;
  logic [9:0]     r_shreg;
  logic [TCW-1:0] r_tocnt;
  logic [7:0]     r_byte;
  logic           r_byte_stb;
  logic           r_bad_stb;
  logic           w_frame_ok;
  state_t         r_state;
  logic [8:0]     w_map;
  logic           w_letter;
  logic [7:0]     w_emit;
`ifdef PS2_SHIFT_EN
  logic           r_shift;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Level changes only after FILTER_LEN consecutive samples disagree with it.
  assign w_fall = r_filt & ~r_clk_s2 & (r_fcnt == FCW'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
      r_filt <= r_clk_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  // After ten right shifts: [0]=start, [8:1]=data, [9]=parity; stop is the live sample.
  assign w_frame_ok = ~r_shreg[0] & r_dat_s2 & (^r_shreg[9:1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt   <= '0;
      r_shreg    <= '0;
      r_tocnt    <= '0;
      r_byte     <= '0;
      r_byte_stb <= 1'b0;
      r_bad_stb  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_byte_stb <= 1'b0;
      r_bad_stb  <= 1'b0;
      frame_err  <= 1'b0;
      if (w_fall) begin
        r_tocnt <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= '0;
          if (w_frame_ok) begin
            r_byte     <= r_shreg[8:1];
            r_byte_stb <= 1'b1;
          end else begin
            r_bad_stb <= 1'b1;
            frame_err <= 1'b1;
          end
        end else begin
          r_shreg  <= {r_dat_s2, r_shreg[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (r_tocnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          r_bitcnt  <= '0;
          r_tocnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          r_tocnt <= r_tocnt + 1'b1;
        end
      end else begin
        r_tocnt <= '0;
      end
    end
  end

  function automatic logic [8:0] f_map(input logic [7:0] sc);
    logic [8:0] m;
    m = '0;
    case (sc)
      8'h45: m = {1'b1, 8'h30};
      8'h16: m = {1'b1, 8'h31};
      8'h1E: m = {1'b1, 8'h32};
      8'h26: m = {1'b1, 8'h33};
      8'h25: m = {1'b1, 8'h34};
      8'h2E: m = {1'b1, 8'h35};
      8'h36: m = {1'b1, 8'h36};
      8'h3D: m = {1'b1, 8'h37};
      8'h3E: m = {1'b1, 8'h38};
      8'h46: m = {1'b1, 8'h39};
      8'h1C: m = {1'b1, 8'h61};
      8'h32: m = {1'b1, 8'h62};
      8'h21: m = {1'b1, 8'h63};
      8'h23: m = {1'b1, 8'h64};
      8'h24: m = {1'b1, 8'h65};
      8'h2B: m = {1'b1, 8'h66};
      8'h34: m = {1'b1, 8'h67};
      8'h33: m = {1'b1, 8'h68};
      8'h43: m = {1'b1, 8'h69};
      8'h3B: m = {1'b1, 8'h6A};
      8'h42: m = {1'b1, 8'h6B};
      8'h4B: m = {1'b1, 8'h6C};
      8'h3A: m = {1'b1, 8'h6D};
      8'h31: m = {1'b1, 8'h6E};
      8'h44: m = {1'b1, 8'h6F};
      8'h4D: m = {1'b1, 8'h70};
      8'h15: m = {1'b1, 8'h71};
      8'h2D: m = {1'b1, 8'h72};
      8'h1B: m = {1'b1, 8'h73};
      8'h2C: m = {1'b1, 8'h74};
      8'h3C: m = {1'b1, 8'h75};
      8'h2A: m = {1'b1, 8'h76};
      8'h1D: m = {1'b1, 8'h77};
      8'h22: m = {1'b1, 8'h78};
      8'h35: m = {1'b1, 8'h79};
      8'h1A: m = {1'b1, 8'h7A};
      8'h5A: m = {1'b1, 8'h0D};
      8'h66: m = {1'b1, 8'h08};
      8'h29: m = {1'b1, 8'h20};
      8'h76: m = {1'b1, 8'h1B};
      default: m = '0;
    endcase
    return m;
  endfunction

  assign w_map    = f_map(r_byte);
  assign w_letter = (w_map[7:0] >= 8'h61) && (w_map[7:0] <= 8'h7A);
`ifdef PS2_SHIFT_EN
  assign w_emit   = (r_shift && w_letter) ? (w_map[7:0] - 8'h20) : w_map[7:0];
`else
  assign w_emit   = w_letter ? w_map[7:0] : w_map[7:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      ascii_code  <= '0;
      ascii_valid <= 1'b0;
`ifdef PS2_SHIFT_EN
      r_shift     <= 1'b0;
`endif
    end else begin
      ascii_valid <= 1'b0;
      if (r_bad_stb) begin
        r_state <= S_IDLE;
      end else if (r_byte_stb) begin
        case (r_state)
          S_IDLE: begin
            if (r_byte == 8'hF0) begin
              r_state <= S_BREAK;
            end else if (r_byte == 8'hE0) begin
              r_state <= S_EXT;
`ifdef PS2_SHIFT_EN
            end else if (r_byte == 8'h12 || r_byte == 8'h59) begin
              r_shift <= 1'b1;
`endif
            end else if (w_map[8]) begin
              ascii_code  <= w_emit;
              ascii_valid <= 1'b1;
            end
          end
          S_BREAK: begin
            r_state <= S_IDLE;
`ifdef PS2_SHIFT_EN
            if (r_byte == 8'h12 || r_byte == 8'h59) r_shift <= 1'b0;
`endif
          end
          S_EXT: begin
            if (r_byte == 8'hF0) begin
              r_state <= S_EXT_BREAK;
            end else begin
              r_state <= S_IDLE;
              if (r_byte == 8'h5A) begin
                ascii_code  <= 8'h0D;
                ascii_valid <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Self-checking bench for ps2_ascii_decoder: table of key presses plus multi-frame corner sequences.
`timescale 1ns/1ps
module tb_ps2_ascii_decoder;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 20;
  localparam int unsigned LAT  = 2 + FILT + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii_code;
  logic       ascii_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_ascii_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ascii_code (ascii_code),
    .ascii_valid(ascii_valid),
    .frame_err  (frame_err)
  );

  typedef struct {logic is_err; logic [7:0] code;} exp_t;
  typedef struct {logic [7:0] sc; bit emit; logic [7:0] asc;} vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_code(input logic [7:0] c);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = c;
    sb.push_back(e);
  endfunction

  function automatic void push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    sb.push_back(e);
  endfunction

  // Scoreboard: every output event must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b0 && (ascii_valid === 1'b1 || frame_err === 1'b1)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: valid=%b err=%b code=%0h, want no event (t=%0t)",
                 ascii_valid, frame_err, ascii_code, $time);
      end else begin
        e = sb.pop_front();
        chk("evt_valid", {31'b0, ascii_valid}, {31'b0, ~e.is_err});
        chk("evt_err", {31'b0, frame_err}, {31'b0, e.is_err});
        if (!e.is_err) chk("evt_code", {24'b0, ascii_code}, {24'b0, e.code});
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit bad_par = 1'b0, input int nb = 11,
                            input bit glitch = 1'b0, input bit chk_lat = 1'b0,
                            input logic [7:0] lat_code = 8'h00);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF / 2) @(negedge clk);
      if (glitch) begin
        ps2_clk = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      if (chk_lat && i == 10) begin
        repeat (LAT - 1) @(posedge clk);
        #1 chk("lat_early", {31'b0, ascii_valid}, 32'd0);
        @(posedge clk);
        #1 chk("lat_valid", {31'b0, ascii_valid}, 32'd1);
        chk("lat_code", {24'b0, ascii_code}, {24'b0, lat_code});
        repeat (HALF - LAT) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{8'h45, 1'b1, 8'h30};
    tbl[1]  = '{8'h1E, 1'b1, 8'h32};
    tbl[2]  = '{8'h46, 1'b1, 8'h39};
    tbl[3]  = '{8'h1C, 1'b1, 8'h61};
    tbl[4]  = '{8'h1A, 1'b1, 8'h7A};
    tbl[5]  = '{8'h4D, 1'b1, 8'h70};
    tbl[6]  = '{8'h5A, 1'b1, 8'h0D};
    tbl[7]  = '{8'h66, 1'b1, 8'h08};
    tbl[8]  = '{8'h29, 1'b1, 8'h20};
    tbl[9]  = '{8'h76, 1'b1, 8'h1B};
    tbl[10] = '{8'h0E, 1'b0, 8'h00};
    tbl[11] = '{8'h77, 1'b0, 8'h00};

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_code", {24'b0, ascii_code}, 32'h0);
    chk("rst_valid", {31'b0, ascii_valid}, 32'h0);
    chk("rst_err", {31'b0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Make 16 with exact latency check, then its release.
    push_code(8'h31);
    send_frame(.d(8'h16), .chk_lat(1'b1), .lat_code(8'h31));
    send_frame(.d(8'hF0));
    send_frame(.d(8'h16));
    chk("hold_code", {24'b0, ascii_code}, 32'h31);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].emit) push_code(tbl[i].asc);
      send_frame(.d(tbl[i].sc));
      send_frame(.d(8'hF0));
      send_frame(.d(tbl[i].sc));
    end

    // Bad parity, then recovery.
    push_err();
    send_frame(.d(8'h15), .bad_par(1'b1));
    push_code(8'h61);
    send_frame(.d(8'h1C));

    // Partial frame times out.
    push_err();
    send_frame(.d(8'h00), .nb(5));
    repeat (TMO + 10) @(negedge clk);
    push_code(8'h30);
    send_frame(.d(8'h45));

    // Typematic repeat emits each time.
    push_code(8'h72);
    send_frame(.d(8'h2D));
    push_code(8'h72);
    send_frame(.d(8'h2D));
    send_frame(.d(8'hF0));
    send_frame(.d(8'h2D));

    // Shift make/break around a letter.
    send_frame(.d(8'h12));
`ifdef PS2_SHIFT_EN
    push_code(8'h41);
`else
    push_code(8'h61);
`endif
    send_frame(.d(8'h1C));
    send_frame(.d(8'hF0));
    send_frame(.d(8'h12));
    push_code(8'h61);
    send_frame(.d(8'h1C));

    // Extended prefixes: only E0 5A emits.
    send_frame(.d(8'hE0));
    push_code(8'h0D);
    send_frame(.d(8'h5A));
    send_frame(.d(8'hE0));
    send_frame(.d(8'hF0));
    send_frame(.d(8'h5A));
    send_frame(.d(8'hE0));
    send_frame(.d(8'h75));
    push_code(8'h61);
    send_frame(.d(8'h1C));

    // Clock glitches during a frame.
    push_code(8'h38);
    send_frame(.d(8'h3E), .glitch(1'b1));

    // Reset mid-frame, then a clean frame.
    send_frame(.d(8'h4D), .nb(6));
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_code", {24'b0, ascii_code}, 32'h0);
    chk("midrst_valid", {31'b0, ascii_valid}, 32'h0);
    chk("midrst_err", {31'b0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    push_code(8'h31);
    send_frame(.d(8'h16));
    repeat (TMO + 50) @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
